// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: captures one record per register write-back edge into a show-ahead FIFO drained over valid/ready
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   debug_wb_pc/_rf_wen/_rf_addr/_rf_wdata   CPU write-back debug bus
//   trace_clr                synchronous flush, also clears overflow and drop count
//   trace_valid/_ready       head record handshake
//   trace_pc/_addr/_data     head record, zero while trace_valid=0
//   trace_level              occupied entries 0..DEPTH
//   trace_overflow           sticky, a record was dropped
//   trace_drop_cnt           saturating count of dropped records
// Build option: TRACE_FILTER_R0_EN ignores write-backs to register 0.
module wb_trace_fifo #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       debug_wb_pc,
    input  logic              debug_wb_rf_wen,
    input  logic [4:0]        debug_wb_rf_addr,
    input  logic [31:0]       debug_wb_rf_wdata,
    input  logic              trace_clr,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [31:0]       trace_pc,
    output logic [4:0]        trace_addr,
    output logic [31:0]       trace_data,
    output logic [AW:0]       trace_level,
    output logic              trace_overflow,
    output logic [DROP_W-1:0] trace_drop_cnt
);
    logic [68:0]       mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic              wen_q;
    logic              evt, full, pop, push, drop;
    logic [68:0]       head;

`ifdef TRACE_FILTER_R0_EN
    assign evt = debug_wb_rf_wen && !wen_q && (debug_wb_rf_addr != 5'd0);
`else
    assign evt = debug_wb_rf_wen && !wen_q;
`endif

    assign full        = trace_level == (AW+1)'(DEPTH);
    assign trace_valid = trace_level != '0;
    assign pop         = trace_valid && trace_ready;
    // a pop on a full FIFO frees the head slot, which the push may reuse in the same cycle
    assign push        = evt && (!full || pop);
    assign drop        = evt && full && !pop;
    assign head        = mem[rd_ptr];
    assign trace_pc    = trace_valid ? head[68:37] : '0;
    assign trace_addr  = trace_valid ? head[36:32] : '0;
    assign trace_data  = trace_valid ? head[31:0]  : '0;

    always_ff @(posedge clk)
        if (push && !trace_clr)
            mem[wr_ptr] <= {debug_wb_pc, debug_wb_rf_addr, debug_wb_rf_wdata};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            trace_level    <= '0;
            trace_overflow <= 1'b0;
            trace_drop_cnt <= '0;
            wen_q          <= 1'b0;
        end else begin
            // tracked even during a flush so a held wen is never seen as a new edge
            wen_q <= debug_wb_rf_wen;
            if (trace_clr) begin
                rd_ptr         <= '0;
                wr_ptr         <= '0;
                trace_level    <= '0;
                trace_overflow <= 1'b0;
                trace_drop_cnt <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                trace_level <= (push && !pop) ? trace_level + 1'b1 :
                               (pop && !push) ? trace_level - 1'b1 : trace_level;
                if (drop) begin
                    trace_overflow <= 1'b1;
                    if (~&trace_drop_cnt)
                        trace_drop_cnt <= trace_drop_cnt + 1'b1;
                end
            end
        end
    end
endmodule
